// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b memory-port types: bus word, byte write mask and responder state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc3b_memresp_state_t;

  localparam int LC3B_MEM_LATENCY_DEFAULT    = 3;
  localparam int LC3B_MEM_ADDR_WIDTH_DEFAULT = 12;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory port: strobes, address and data from the datapath,
// completion pulse, read data and protocol-error flag from the memory side.
interface lc3b_mem_responder_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  logic          mem_resp;
  lc3b_word      mem_rdata;
  logic          proto_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata, proto_err
  );

endinterface

// File: rtl/lc3b_mem_responder_array.sv
// Word storage split into two byte lanes so each byte has its own write enable.
// Reads are combinational so the responder can load read data on the edge
// that enters its response cycle. Contents are never reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_MEM_ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  lc3b_mem_wmask         be,
  input  lc3b_word              wdata,
  output lc3b_word              rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Commit this byte lane only when its enable bit is set.
      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b multicycle datapath. Accepts one
// read/write request at a time, holds it for a fixed latency, then answers
// with a one-cycle mem_resp. Address, data and mask are captured at
// acceptance and the live bus values are ignored afterwards.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_MEM_ADDR_WIDTH_DEFAULT,
  parameter int LATENCY    = LC3B_MEM_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lc3b_mem_responder_if.slave  bus
);

  // WAIT is entered with LATENCY-2 so that the response lands LATENCY cycles
  // after the accepting cycle (one cycle to enter WAIT, one to enter RESP).
  localparam logic [3:0] CNT_START = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  lc3b_memresp_state_t   state_reg;
  logic [3:0]            cnt_reg;
  logic                  op_write_reg;
  logic [ADDR_WIDTH-1:0] index_reg;
  lc3b_word              wdata_reg;
  lc3b_mem_wmask         be_reg;
  logic                  resp_reg;
  lc3b_word              rdata_reg;
  logic                  proto_err_reg;

  logic [ADDR_WIDTH-1:0] live_index;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic                  arr_we;
  lc3b_word              arr_rdata;
  logic                  strobe_held;
  logic                  addr_unused;

  // Bit 0 selects a byte within the word and the top bits alias; neither
  // takes part in indexing.
  assign live_index  = bus.mem_address[ADDR_WIDTH:1];
  assign addr_unused = ^{bus.mem_address >> (ADDR_WIDTH + 1), bus.mem_address[0]};

  // While idle the array looks at the live address so a LATENCY==1 read can
  // load its data on the accepting edge; otherwise the captured index is used.
  assign arr_addr    = (state_reg == IDLE) ? live_index : index_reg;
  assign arr_we      = (state_reg == RESP) && op_write_reg;

  // The op stays alive only while the strobe that started it stays high.
  assign strobe_held = op_write_reg ? bus.mem_write : bus.mem_read;

  lc3b_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .we    (arr_we),
    .be    (be_reg),
    .wdata (wdata_reg),
    .rdata (arr_rdata)
  );

  // Request FSM: accept, count down latency, pulse response, back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      op_write_reg  <= 1'b0;
      index_reg     <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      resp_reg      <= 1'b0;
      rdata_reg     <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      resp_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            op_write_reg <= bus.mem_write;
            index_reg    <= live_index;
            wdata_reg    <= bus.mem_wdata;
            be_reg       <= bus.mem_byte_enable;
            if (bus.mem_read && bus.mem_write) begin
              proto_err_reg <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_reg <= RESP;
              resp_reg  <= 1'b1;
              if (!bus.mem_write) begin
                rdata_reg <= arr_rdata;
              end
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_START;
            end
          end
        end
        WAIT: begin
          if (!strobe_held) begin
            state_reg <= IDLE;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
            if (!op_write_reg) begin
              rdata_reg <= arr_rdata;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp  = resp_reg;
  assign bus.mem_rdata = rdata_reg;
  assign bus.proto_err = proto_err_reg;

endmodule
